// File: rtl/reg_status_file_if.sv
// Issue, commit and read-port bundle for the register status file; master drives, slave answers.
// Reads are combinational, so there is no handshake on this bundle.
interface reg_status_file_if #(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 4,
    parameter int RD_PORTS  = 2
);
    logic                          issue_valid;
    logic [4:0]                    issue_rd;
    logic [ROB_WIDTH-1:0]          issue_tag;

    logic                          commit_valid;
    logic [4:0]                    commit_rd;
    logic [XLEN-1:0]               commit_val;
    logic [ROB_WIDTH-1:0]          commit_tag;

    logic [RD_PORTS*5-1:0]         rd_id;
    logic [RD_PORTS*XLEN-1:0]      rd_val;
    logic [RD_PORTS-1:0]           rd_busy;
    logic [RD_PORTS*ROB_WIDTH-1:0] rd_tag;

    logic [5:0]                    busy_count;

    modport master (
        output issue_valid, issue_rd, issue_tag,
        output commit_valid, commit_rd, commit_val, commit_tag,
        output rd_id,
        input  rd_val, rd_busy, rd_tag, busy_count
    );

    modport slave (
        input  issue_valid, issue_rd, issue_tag,
        input  commit_valid, commit_rd, commit_val, commit_tag,
        input  rd_id,
        output rd_val, rd_busy, rd_tag, busy_count
    );
endinterface

// File: rtl/reg_status_file.sv
// 32-entry register value/busy/tag file: combinational reads with commit bypass, one-edge update.
// rdy_in low freezes all state; read ports and commit bypass stay live.
module reg_status_file #(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 4,
    parameter int RD_PORTS  = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clr_in,
    reg_status_file_if.slave   bus
);

    logic [XLEN-1:0]      val_q [32];
    logic [XLEN-1:0]      val_d [32];
    logic [ROB_WIDTH-1:0] tag_q [32];
    logic [ROB_WIDTH-1:0] tag_d [32];
    logic [31:0]          busy_q, busy_d;
    logic [5:0]           cnt_q, cnt_d;

    logic do_commit, do_issue, commit_hit, same_reg, inc, dec;

    assign do_commit  = bus.commit_valid && rdy_in && (bus.commit_rd != 5'd0);
    assign do_issue   = bus.issue_valid && rdy_in && !clr_in && (bus.issue_rd != 5'd0);
    assign commit_hit = do_commit && busy_q[bus.commit_rd]
                        && (tag_q[bus.commit_rd] == bus.commit_tag);
    assign same_reg   = do_issue && (bus.issue_rd == bus.commit_rd);
    assign inc        = do_issue && !busy_q[bus.issue_rd];
    // A same-register issue keeps the entry busy, so the retiring producer is not counted down.
    assign dec        = commit_hit && !same_reg;

    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (do_commit) begin
            val_d[bus.commit_rd] = bus.commit_val;
            if (commit_hit) begin
                busy_d[bus.commit_rd] = 1'b0;
            end
        end
        if (rdy_in && clr_in) begin
            busy_d = '0;
            cnt_d  = '0;
            for (int i = 0; i < 32; i++) begin
                tag_d[i] = '0;
            end
        end else if (rdy_in) begin
            if (do_issue) begin
                busy_d[bus.issue_rd] = 1'b1;
                tag_d[bus.issue_rd]  = bus.issue_tag;
            end
            cnt_d = cnt_q + {5'd0, inc} - {5'd0, dec};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.busy_count = cnt_q;

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [4:0] id;
        logic       byp, byp_hit, busy_k;

        assign id      = bus.rd_id[5*k +: 5];
        // Bypass is gated by reset so every output reads zero while reset is held.
        assign byp     = !rst_in && bus.commit_valid && (bus.commit_rd == id) && (id != 5'd0);
        assign byp_hit = byp && busy_q[id] && (tag_q[id] == bus.commit_tag);
        assign busy_k  = busy_q[id] && !byp_hit;

        assign bus.rd_val[XLEN*k +: XLEN]           = byp ? bus.commit_val : val_q[id];
        assign bus.rd_busy[k]                       = busy_k;
        assign bus.rd_tag[ROB_WIDTH*k +: ROB_WIDTH] = busy_k ? tag_q[id] : '0;
    end

endmodule
